// File: rtl/state_histogram_if.sv
// Control, configuration, readout and status bundle for state_histogram.
// master drives the run controls and the p-bit vector; slave is the histogram.
interface state_histogram_if #(
    parameter int STATE_W = 5,
    parameter int CNT_W   = 16,
    parameter int NS_W    = 20
);
    logic [STATE_W-1:0] state_in;
    logic               start;
    logic               stop;
    logic [7:0]         decim;
    logic [NS_W-1:0]    num_samples;
    logic [STATE_W-1:0] rd_addr;
    logic [CNT_W-1:0]   rd_data;
    logic               busy;
    logic               done;
    logic               sat;
    logic [NS_W-1:0]    samples_taken;

    modport master (
        output state_in, start, stop, decim, num_samples, rd_addr,
        input  rd_data, busy, done, sat, samples_taken
    );

    modport slave (
        input  state_in, start, stop, decim, num_samples, rd_addr,
        output rd_data, busy, done, sat, samples_taken
    );
endinterface

// File: rtl/state_histogram.sv
// Histogram of a p-bit state vector: every decim+1 cycles during a run the
// (twice re-registered) state selects one of 2^STATE_W saturating bin counters.
// Bins are readable through a registered port while no run is active.
module state_histogram #(
    parameter int STATE_W = 5,
    parameter int CNT_W   = 16,
    parameter int NS_W    = 20
) (
    input logic                clk,
    input logic                rst,
    state_histogram_if.slave   bus
);
    localparam int               NBINS   = 1 << STATE_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [STATE_W-1:0] s1_q, s2_q;
    logic [7:0]         decim_q, dcnt_q;
    logic [NS_W-1:0]    num_q, taken_q;
    logic               sat_q, done_q;
    logic [CNT_W-1:0]   rd_data_q;
    logic [CNT_W-1:0]   bin_q [NBINS];

    logic start_acc;  // accepted start: clear bins/status and latch config
    logic sample_en;  // bin s2 this edge
    logic done_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state and per-edge strobes; stop wins over start and sampling
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        sample_en = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    start_acc = 1'b1;
                    if (bus.num_samples != '0) begin
                        state_d = StRun;
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StRun: begin
                if (bus.stop) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (dcnt_q == decim_q) begin
                    sample_en = 1'b1;
                    if (taken_q + NS_W'(1) == num_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Two-stage capture of the state vector, which arrives from other clock phases
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus.state_in;
            s2_q <= s1_q;
        end
    end

    // Run configuration, decimation counter and sample count
    always_ff @(posedge clk) begin
        if (rst) begin
            decim_q <= '0;
            num_q   <= '0;
            dcnt_q  <= '0;
            taken_q <= '0;
        end else if (start_acc) begin
            decim_q <= bus.decim;
            num_q   <= bus.num_samples;
            dcnt_q  <= '0;
            taken_q <= '0;
        end else if (state_q == StRun && !bus.stop) begin
            if (sample_en) begin
                dcnt_q  <= '0;
                taken_q <= taken_q + NS_W'(1);
            end else begin
                dcnt_q <= dcnt_q + 8'd1;
            end
        end
    end

    // Saturating bin counters
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBINS; i++) begin
            if (rst || start_acc) begin
                bin_q[i] <= '0;
            end else if (sample_en && s2_q == STATE_W'(i) && bin_q[i] != CNT_MAX) begin
                bin_q[i] <= bin_q[i] + CNT_W'(1);
            end
        end
    end

    // Sticky saturation flag and one-cycle done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (start_acc) sat_q <= 1'b0;
            else if (sample_en && bin_q[s2_q] == CNT_MAX) sat_q <= 1'b1;
        end
    end

    // Registered readout, forced to zero while a run is active
    always_ff @(posedge clk) begin
        if (rst || state_q == StRun) rd_data_q <= '0;
        else                         rd_data_q <= bin_q[bus.rd_addr];
    end

    assign bus.busy          = (state_q == StRun);
    assign bus.done          = done_q;
    assign bus.sat           = sat_q;
    assign bus.samples_taken = taken_q;
    assign bus.rd_data       = rd_data_q;
endmodule

// File: tb/tb_state_histogram.sv
// Directed bench for state_histogram: two instances (16-bit and 4-bit bins)
// share stimulus; a behavioural model predicts bins, and expected done
// latencies and readout values go through scoreboard queues.
module tb_state_histogram;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    state_histogram_if #(.STATE_W(5), .CNT_W(16), .NS_W(20)) bus ();
    state_histogram_if #(.STATE_W(5), .CNT_W(4),  .NS_W(20)) bus4 ();

    assign bus4.state_in    = bus.state_in;
    assign bus4.start       = bus.start;
    assign bus4.stop        = bus.stop;
    assign bus4.decim       = bus.decim;
    assign bus4.num_samples = bus.num_samples;
    assign bus4.rd_addr     = bus.rd_addr;

    state_histogram #(.STATE_W(5), .CNT_W(16), .NS_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    state_histogram #(.STATE_W(5), .CNT_W(4), .NS_W(20)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    int checks   = 0;
    int failures = 0;

    int exp_bin16 [32];
    int exp_bin4  [32];
    int exp_taken;
    bit exp_sat16;
    bit exp_sat4;

    int lat_q  [$];
    int rd16_q [$];
    int rd4_q  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // State present at edge e relative to the start edge (mode 0: constant c,
    // mode 1: 0 on even edges, all-ones on odd edges)
    function automatic logic [4:0] pat(input int mode, input logic [4:0] c, input int e);
        if (mode == 0) return c;
        return (e % 2 != 0) ? 5'b11111 : 5'b00000;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            exp_bin16[i] = 0;
            exp_bin4[i]  = 0;
        end
        exp_taken = 0;
        exp_sat16 = 1'b0;
        exp_sat4  = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 32; a++) begin
            bus.rd_addr = 5'(a);
            rd16_q.push_back(exp_bin16[a]);
            rd4_q.push_back(exp_bin4[a]);
            tick();
            check({tag, "_bin16"}, 32'(bus.rd_data), rd16_q.pop_front());
            check({tag, "_bin4"}, 32'(bus4.rd_data), rd4_q.pop_front());
        end
    endtask

    task automatic run(input string tag, input int d, input int n, input int mode,
                       input logic [4:0] c, input int stop_at, input bit start_with_stop);
        int         exp_lat;
        bit         seen;
        logic [4:0] v;
        exp_lat = n * (d + 1);
        if (stop_at > 0 && stop_at < exp_lat) exp_lat = stop_at;
        bus.state_in = pat(mode, c, -2);
        tick();
        bus.state_in = pat(mode, c, -1);
        tick();
        bus.start       = 1'b1;
        bus.decim       = 8'(d);
        bus.num_samples = 20'(n);
        bus.state_in    = pat(mode, c, 0);
        lat_q.push_back(exp_lat);
        clear_model();
        tick();
        bus.start = 1'b0;
        seen = 1'b0;
        for (int e = 0; e <= exp_lat + 4; e++) begin
            if (e > 0) begin
                bus.state_in = pat(mode, c, e);
                bus.stop     = (e == stop_at);
                bus.start    = start_with_stop && (e == stop_at);
                tick();
                bus.stop  = 1'b0;
                bus.start = 1'b0;
                if (!(stop_at > 0 && e >= stop_at) && e % (d + 1) == 0 && exp_taken < n) begin
                    v = pat(mode, c, e - 2);
                    if (exp_bin16[v] == 65535) exp_sat16 = 1'b1;
                    else exp_bin16[v]++;
                    if (exp_bin4[v] == 15) exp_sat4 = 1'b1;
                    else exp_bin4[v]++;
                    exp_taken++;
                end
            end
            if (e == 0) check({tag, "_busy_after_start"}, 32'(bus.busy), (n > 0) ? 1 : 0);
            if (e == 1) check({tag, "_rd_while_busy"}, 32'(bus.rd_data), 0);
            if (bus.done) begin
                check({tag, "_done_latency"}, e, lat_q.pop_front());
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (!seen) void'(lat_q.pop_front());
        tick();
        check({tag, "_done_one_cycle"}, 32'(bus.done), 0);
        check({tag, "_busy_after"}, 32'(bus.busy), 0);
        check({tag, "_taken16"}, 32'(bus.samples_taken), exp_taken);
        check({tag, "_taken4"}, 32'(bus4.samples_taken), exp_taken);
        check({tag, "_sat16"}, 32'(bus.sat), 32'(exp_sat16));
        check({tag, "_sat4"}, 32'(bus4.sat), 32'(exp_sat4));
    endtask

    initial begin
        rst             = 1'b1;
        bus.state_in    = '0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.decim       = '0;
        bus.num_samples = '0;
        bus.rd_addr     = '0;
        clear_model();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_sat", 32'(bus.sat), 0);
        check("reset_taken", 32'(bus.samples_taken), 0);
        read_all("reset");

        // Constant 10001, every cycle, 10 samples
        run("const17", 0, 10, 0, 5'b10001, 0, 1'b0);
        read_all("const17");

        // Decimated toggling input exposes the two-cycle capture latency
        bus.rd_addr = 5'd17;
        run("toggle", 3, 4, 1, 5'b00000, 0, 1'b0);
        read_all("toggle");

        // 4-bit bins saturate at 15
        run("satur", 0, 20, 0, 5'b01110, 0, 1'b0);
        read_all("satur");

        // Stop (with start also high) on the 40th run edge
        run("stop40", 0, 100, 1, 5'b00000, 40, 1'b1);
        read_all("stop40");

        // Zero-sample start: clears bins, no run, done next cycle
        run("nsamp0", 5, 0, 0, 5'b00011, 0, 1'b0);
        read_all("nsamp0");

        // Reset in the middle of a run
        bus.state_in    = 5'b00011;
        bus.decim       = 8'd0;
        bus.num_samples = 20'd100;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        check("midrst_busy_before", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.done), 0);
        check("midrst_taken", 32'(bus.samples_taken), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst_no_done", 32'(bus.done), 0);
        end
        clear_model();
        read_all("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
